// File: rtl/hmc_pkg.sv
// Shared types and sizing helpers for the HMC link power controller.
package hmc_pkg;

  typedef enum logic [2:0] {
    RESET_WAIT  = 3'd0,
    ACTIVE      = 3'd1,
    SLEEP_ENTRY = 3'd2,
    SLEEP       = 3'd3,
    WAKE_WAIT   = 3'd4,
    FATAL       = 3'd5
  } pwr_state_t;

  localparam int T_RESP_MAX_DFLT = 4096;
  localparam int CNT_W = $clog2(T_RESP_MAX_DFLT + 1);

  // Handshake counter width; it must be able to hold T_RESP_MAX itself.
  function automatic int cnt_w_of(input int t_resp_max);
    return $clog2(t_resp_max + 1);
  endfunction

endpackage

// File: rtl/hmc_sync2.sv
// Two-flop synchroniser for asynchronous device status pins.
module hmc_sync2 import hmc_pkg::*; #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; only q is used by downstream logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hmc_link_pwr_ctrl.sv
// Host-side HMC link power / lane-width controller: RXPS/TXPS sleep and
// wake handshake, FERR_N fatal latch and half-width degradation.
module hmc_link_pwr_ctrl import hmc_pkg::*; #(
  parameter int NUM_LANES     = 16,
  parameter int T_PST_CYC     = 80,
  parameter int T_SS_CYC      = 500,
  parameter int T_RESP_MAX    = 4096,
  parameter int ERR_THRESH    = 15,
  parameter int HALF_WIDTH_EN = 1
) (
  input  logic                 REFCLK,
  input  logic                 P_RST_N,
  input  logic                 link_up,
  input  logic [NUM_LANES-1:0] lane_mask_cfg,
  input  logic                 sleep_req,
  input  logic                 wake_req,
  input  logic                 err_clr,
  input  logic [NUM_LANES-1:0] lane_err,
  input  logic                 TXPS,
  input  logic                 FERR_N,
  output logic                 RXPS,
  output logic [NUM_LANES-1:0] lane_en,
  output logic [2:0]           pwr_state,
  output logic                 sleep_ack,
  output logic                 wake_done,
  output logic                 degraded,
  output logic                 timeout_err,
  output logic                 fatal_err
);

  localparam int CW  = cnt_w_of(T_RESP_MAX);
  localparam int PCW = $clog2(NUM_LANES + 1);
  localparam logic [CW-1:0] PST_C  = CW'(T_PST_CYC);
  localparam logic [CW-1:0] SS_C   = CW'(T_SS_CYC);
  localparam logic [CW-1:0] RESP_C = CW'(T_RESP_MAX);
  localparam logic [NUM_LANES-1:0] LO_MASK =
    {{(NUM_LANES/2){1'b0}}, {(NUM_LANES/2){1'b1}}};

  pwr_state_t           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 rxps_q, rxps_d;
  logic [NUM_LANES-1:0] lane_q, lane_d, mask_q, mask_d, lane_hit;
  logic                 ack_q, ack_d, wdone_q, wdone_d;
  logic                 deg_q, deg_d, tout_q, tout_d, fatal_q, fatal_d;
  logic [7:0]           ecnt_q, ecnt_d;
  logic [PCW-1:0]       pc;
  logic [8:0]           esum;
  logic                 deg_hit;
  logic                 ts, fs;

  // TXPS idles high (normal power); FERR_N idles high (no fault).
  hmc_sync2 #(.RST_VAL(1'b1)) u_ts (.clk(REFCLK), .rst_n(P_RST_N), .d(TXPS),   .q(ts));
  hmc_sync2 #(.RST_VAL(1'b1)) u_fs (.clk(REFCLK), .rst_n(P_RST_N), .d(FERR_N), .q(fs));

  assign lane_hit = lane_err & lane_q;

  // Count error strobes on lanes that are currently enabled.
  always_comb begin
    pc = '0;
    for (int i = 0; i < NUM_LANES; i++) pc = pc + PCW'(lane_hit[i]);
  end

  assign esum    = {1'b0, ecnt_q} + 9'(pc);
  assign deg_hit = (HALF_WIDTH_EN != 0) && ({24'd0, ecnt_q} >= ERR_THRESH);

  // Next-state and output decode; fatal input overrides every handshake step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rxps_d  = rxps_q;
    lane_d  = lane_q;
    mask_d  = mask_q;
    ack_d   = 1'b0;
    wdone_d = 1'b0;
    deg_d   = deg_q | deg_hit;
    tout_d  = tout_q & ~(err_clr && state_q != FATAL);
    fatal_d = fatal_q;
    ecnt_d  = ecnt_q;
    if (state_q == ACTIVE) ecnt_d = esum[8] ? 8'hFF : esum[7:0];
    if (!fs && state_q != FATAL) begin
      state_d = FATAL;
      fatal_d = 1'b1;
      lane_d  = '0;
    end else begin
      case (state_q)
        RESET_WAIT: if (link_up) begin
          state_d = ACTIVE;
          lane_d  = lane_mask_cfg;
          mask_d  = lane_mask_cfg;
        end
        ACTIVE: if (sleep_req) begin
          state_d = SLEEP_ENTRY;
          rxps_d  = 1'b0;
          cnt_d   = '0;
        end
        SLEEP_ENTRY: begin
          if (!ts && cnt_q >= PST_C) begin
            state_d = SLEEP;
            lane_d  = '0;
            ack_d   = 1'b1;
          end else if (cnt_q == RESP_C) begin
            // Device never answered: back out and keep the lanes as they were.
            state_d = ACTIVE;
            tout_d  = 1'b1;
            rxps_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        SLEEP: if (wake_req) begin
          state_d = WAKE_WAIT;
          rxps_d  = 1'b1;
          cnt_d   = '0;
        end
        WAKE_WAIT: begin
          if (ts && cnt_q >= SS_C) begin
            state_d = ACTIVE;
            lane_d  = mask_q;
            wdone_d = 1'b1;
          end else if (cnt_q == RESP_C) begin
            // A device that will not wake is unrecoverable without err_clr;
            // fatal_err stays reserved for the FERR_N pin.
            state_d = FATAL;
            tout_d  = 1'b1;
            lane_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        FATAL: if (err_clr && fs) begin
          state_d = RESET_WAIT;
          fatal_d = 1'b0;
          tout_d  = 1'b0;
          deg_d   = 1'b0;
          ecnt_d  = '0;
          rxps_d  = 1'b1;
        end
        default: state_d = RESET_WAIT;
      endcase
    end
    // Once degraded the upper half never comes back until FATAL release.
    if (deg_d) lane_d = lane_d & LO_MASK;
  end

  // State and output registers.
  always_ff @(posedge REFCLK or negedge P_RST_N) begin
    if (!P_RST_N) begin
      state_q <= RESET_WAIT;
      cnt_q   <= '0;
      rxps_q  <= 1'b1;
      lane_q  <= '0;
      mask_q  <= '0;
      ack_q   <= 1'b0;
      wdone_q <= 1'b0;
      deg_q   <= 1'b0;
      tout_q  <= 1'b0;
      fatal_q <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rxps_q  <= rxps_d;
      lane_q  <= lane_d;
      mask_q  <= mask_d;
      ack_q   <= ack_d;
      wdone_q <= wdone_d;
      deg_q   <= deg_d;
      tout_q  <= tout_d;
      fatal_q <= fatal_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign RXPS        = rxps_q;
  assign lane_en     = lane_q;
  assign pwr_state   = state_q;
  assign sleep_ack   = ack_q;
  assign wake_done   = wdone_q;
  assign degraded    = deg_q;
  assign timeout_err = tout_q;
  assign fatal_err   = fatal_q;

endmodule

// File: doc/hmc_link_pwr_ctrl.md
Name: hmc_link_pwr_ctrl

Overview:
Host-side HMC link power and lane-width controller, parametrised in lane count.
- Drives the RXPS power-reduction input and per-lane enables toward the HMC.
- Runs the sleep-entry and wake-up handshake against TXPS, with tPST/tSS timing and response timeouts.
- Latches the FERR_N fatal indicator and degrades to half width on excessive lane errors.
- Sits between the host link controller and the serial lane drivers of the HMC agent.

Parameters:
NUM_LANES, 16, lane count; 8 or 16 only.
T_PST_CYC, 80, minimum REFCLK cycles RXPS is held low before sleep is declared.
T_SS_CYC, 500, minimum REFCLK cycles after RXPS rises before the link is declared active.
T_RESP_MAX, 4096, TXPS response timeout in cycles; must exceed T_PST_CYC and T_SS_CYC.
ERR_THRESH, 15, accumulated lane errors that trigger half-width degradation.
HALF_WIDTH_EN, 1, when 1, degradation is allowed.

Ports:
REFCLK  in  1  single-ended link reference clock; all logic is on this clock.
P_RST_N  in  1  asynchronous active-low reset.
link_up  in  1  PHY training complete.
lane_mask_cfg  in  NUM_LANES  requested enabled lanes; sampled on entry to ACTIVE.
sleep_req  in  1  level; request sleep.
wake_req  in  1  level; request wake.
err_clr  in  1  pulse; clears sticky errors and releases FATAL.
lane_err  in  NUM_LANES  per-lane error strobes.
TXPS  in  1  device power-state output, asynchronous.
FERR_N  in  1  device fatal error, active-low, asynchronous.
RXPS  out  1  device power-reduction input; 1 = normal, 0 = sleep.
lane_en  out  NUM_LANES  per-lane enable.
pwr_state  out  3  current state encoding.
sleep_ack  out  1  one-cycle pulse on SLEEP entry.
wake_done  out  1  one-cycle pulse on ACTIVE entry from WAKE_WAIT.
degraded  out  1  sticky; upper half of lanes disabled.
timeout_err  out  1  sticky.
fatal_err  out  1  sticky.

Behaviour:
Reset values:
- RXPS=1; lane_en=0; pwr_state=RESET_WAIT.
- sleep_ack, wake_done, degraded, timeout_err, fatal_err = 0.
- Cycle counter and error counter = 0.

Input synchronisation:
- TXPS and FERR_N pass through 2-flop synchronisers (ts, fs); decisions use synchronised values only.
- FERR_N synchronisers reset to 1.

State transitions:
- Priority: fs==0 in any non-FATAL state -> FATAL next cycle. fatal_err=1, lane_en=0, RXPS keeps its current value.
- RESET_WAIT: link_up -> ACTIVE. lane_en = lane_mask_cfg, with the upper half masked if degraded.
- ACTIVE: sleep_req -> SLEEP_ENTRY. RXPS=0 from the next cycle; counter cleared.
- SLEEP_ENTRY: counter increments each cycle.
  - ts==0 and counter>=T_PST_CYC -> SLEEP. lane_en=0; sleep_ack pulses on the first SLEEP cycle.
  - counter==T_RESP_MAX -> timeout_err=1, RXPS=1, return to ACTIVE with lane_en unchanged.
- SLEEP: wake_req -> WAKE_WAIT. RXPS=1; counter cleared.
- WAKE_WAIT: counter increments each cycle.
  - ts==1 and counter>=T_SS_CYC -> ACTIVE. Restore lane_en from the saved mask; wake_done pulses.
  - counter==T_RESP_MAX -> timeout_err=1 and go to FATAL.
- FATAL: err_clr and fs==1 -> RESET_WAIT. Clears fatal_err, timeout_err, degraded and the error counter; RXPS=1.

Simultaneous events:
- sleep_req and wake_req together: sleep wins in ACTIVE; wake wins in SLEEP.
- sleep_req during SLEEP_ENTRY or WAKE_WAIT is ignored.
- err_clr outside FATAL clears timeout_err only.

Lane errors:
- Error counter: 8-bit, saturating; adds popcount(lane_err & lane_en) each cycle in ACTIVE only.
- At counter>=ERR_THRESH with HALF_WIDTH_EN=1: degraded=1 and lane_en[NUM_LANES-1:NUM_LANES/2]=0 on the next cycle.
- Degradation persists across sleep/wake.

Reset:
- P_RST_N low mid-handshake returns everything to reset values immediately, asynchronously.

Decomposition:
- Package hmc_pkg:
  - pwr_state_t enum (3-bit): RESET_WAIT=0, ACTIVE=1, SLEEP_ENTRY=2, SLEEP=3, WAKE_WAIT=4, FATAL=5.
  - Counter width constant CNT_W = $clog2(T_RESP_MAX+1).
- Sub-module hmc_sync2: 2-flop synchroniser with a reset-value parameter, instantiated for TXPS and FERR_N.

Test Plan:
1. Reset, then link_up=1, lane_mask_cfg=16'hFFFF -> pwr_state=ACTIVE, lane_en=FFFF, RXPS=1.
2. sleep_req; TXPS driven low 20 cycles later -> RXPS=0; SLEEP reached at counter=80; sleep_ack one cycle; lane_en=0.
3. From SLEEP, wake_req; TXPS high after 100 cycles -> ACTIVE at counter=500; wake_done pulse; lane_en=FFFF.
4. sleep_req with TXPS held high -> timeout_err=1 after 4096 cycles; RXPS=1; state ACTIVE.
5. FERR_N low during WAKE_WAIT -> FATAL within 3 cycles, fatal_err=1, lane_en=0. err_clr with FERR_N high -> RESET_WAIT, flags cleared.
6. lane_err=16'h0003 for 8 cycles in ACTIVE -> count reaches 16>=15, degraded=1, lane_en=00FF; persists after a sleep/wake cycle.
